lock_sequencer: RTL and testbench

Keypad-facing controller for the digital door lock. Accepts decoded key strobes and drives the password comparator/storage path: digit writes into the input buffer, compare pulses, input-buffer clears, answer commits and answer initialization. Tracks failed attempts, holds the door open for a fixed window, enforces a lockout after repeated failures, and runs the password-change sequence.

---
 rtl/lock_pkg.sv | 37 +++
 rtl/lock_timer.sv | 34 +++
 rtl/lock_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_lock_sequencer.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lock_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lock_pkg
//  Description : Shared types and constants for the door-lock keypad
//                sequencer: FSM state encoding, key codes, digit limits.
//  Revision    : 1.0  initial release
// ============================================================================
package lock_pkg;

   typedef enum logic [2:0] {
      ST_INIT    = 3'd0,
      ST_IDLE    = 3'd1,
      ST_ENTRY   = 3'd2,
      ST_CHECK   = 3'd3,
      ST_OPEN    = 3'd4,
      ST_SET     = 3'd5,
      ST_LOCKOUT = 3'd6
   } lock_state_t;

   localparam logic [3:0] KEY_STAR   = 4'hA;
   localparam logic [3:0] KEY_HASH   = 4'hB;

   localparam logic [2:0] MIN_DIGITS = 3'd4;
   localparam logic [2:0] MAX_DIGITS = 3'd6;

   // One-hot input-buffer slot for digit position idx (0..5).
   function automatic logic [5:0] digit_select(input logic [2:0] idx);
      return 6'b000001 << idx;
   endfunction

   // Codes 0..9 are BCD digits; everything above is a control or junk code.
   function automatic logic is_digit(input logic [3:0] code);
      return (code <= 4'd9);
   endfunction

endpackage
`default_nettype wire

// File: rtl/lock_timer.sv
`default_nettype none
// ============================================================================
//  Module      : lock_timer
//  Description : Loadable 16-bit saturating down-counter. o_done flags the
//                last cycle of a timed window, so a load of 0 or 1 both give
//                a single-cycle window and a load of N gives N cycles.
//  Revision    : 1.0  initial release
// ============================================================================
module lock_timer (
   input  logic        clk,
   input  logic        reset,
   input  logic        i_load,
   input  logic [15:0] i_load_value,
   input  logic        i_en,
   output logic        o_done
);

   logic [15:0] r_count;

   // Load takes priority; otherwise count down while enabled, stopping at 0.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_count <= 16'd0;
      end else if (i_load) begin
         r_count <= i_load_value;
      end else if (i_en && (r_count != 16'd0)) begin
         r_count <= r_count - 16'd1;
      end
   end

   assign o_done = (r_count <= 16'd1);

endmodule
`default_nettype wire

// File: rtl/lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : lock_sequencer
//  Description : Keypad-facing controller for the digital door lock. Turns
//                key strobes into input-buffer writes, compare/commit/clear
//                pulses, tracks failed attempts, times the open window and
//                the lockout, and runs the password-change sequence.
//  Revision    : 1.0  initial release
// ============================================================================
module lock_sequencer
   import lock_pkg::*;
#(
   parameter logic [15:0] OPEN_CYCLES    = 16'd50000,
   parameter logic [15:0] LOCKOUT_CYCLES = 16'd60000,
   parameter logic [1:0]  MAX_FAILS      = 2'd3
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       key_valid,
   input  logic [3:0] key_code,
   input  logic       correct,
   output logic [3:0] data,
   output logic [5:0] cs,
   output logic [2:0] digit_count,
   output logic       compare,
   output logic       wr,
   output logic       clear_input,
   output logic       initialize,
   output logic       unlocked,
   output logic       alarm,
   output logic [1:0] fail_count
);

   lock_state_t r_state, w_state_next;

   logic [3:0]  r_data,        w_data_next;
   logic [5:0]  r_cs,          w_cs_next;
   logic [2:0]  r_digit_count, w_digit_count_next;
   logic        r_compare,     w_compare_next;
   logic        r_wr,          w_wr_next;
   logic        r_clear_input, w_clear_input_next;
   logic        r_initialize,  w_initialize_next;
   logic        r_unlocked,    w_unlocked_next;
   logic        r_alarm,       w_alarm_next;
   logic [1:0]  r_fail_count,  w_fail_count_next;

   logic        w_busy, w_key_ok, w_digit, w_star, w_hash;
   logic        w_room, w_enough, w_check_now, w_trip;
   logic [1:0]  w_fail_inc;
   logic        w_tmr_load, w_tmr_en, w_tmr_done;
   logic [15:0] w_tmr_value;

   // Keys landing on a pulse cycle are dropped rather than queued.
   assign w_busy      = r_compare | r_wr | r_clear_input | r_initialize;
   assign w_key_ok    = key_valid & ~w_busy;
   assign w_digit     = w_key_ok & is_digit(key_code);
   assign w_star      = w_key_ok & (key_code == KEY_STAR);
   assign w_hash      = w_key_ok & (key_code == KEY_HASH);
   assign w_room      = (r_digit_count < MAX_DIGITS);
   assign w_enough    = (r_digit_count >= MIN_DIGITS);
   // CHECK spends its first cycle with compare out; the comparator answer
   // is valid on the following edge.
   assign w_check_now = (r_state == ST_CHECK) && !r_compare;
   assign w_fail_inc  = (r_fail_count == 2'd3) ? 2'd3 : (r_fail_count + 2'd1);
   assign w_trip      = (w_fail_inc >= MAX_FAILS);

   assign w_tmr_load  = w_check_now;
   assign w_tmr_value = correct ? OPEN_CYCLES : LOCKOUT_CYCLES;
   assign w_tmr_en    = (r_state == ST_OPEN) || (r_state == ST_LOCKOUT);

   lock_timer u_timer (
      .clk          (clk),
      .reset        (reset),
      .i_load       (w_tmr_load),
      .i_load_value (w_tmr_value),
      .i_en         (w_tmr_en),
      .o_done       (w_tmr_done)
   );

   // State and every output are registered together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= ST_INIT;
         r_data        <= 4'd0;
         r_cs          <= 6'd0;
         r_digit_count <= 3'd0;
         r_compare     <= 1'b0;
         r_wr          <= 1'b0;
         r_clear_input <= 1'b0;
         r_initialize  <= 1'b0;
         r_unlocked    <= 1'b0;
         r_alarm       <= 1'b0;
         r_fail_count  <= 2'd0;
      end else begin
         r_state       <= w_state_next;
         r_data        <= w_data_next;
         r_cs          <= w_cs_next;
         r_digit_count <= w_digit_count_next;
         r_compare     <= w_compare_next;
         r_wr          <= w_wr_next;
         r_clear_input <= w_clear_input_next;
         r_initialize  <= w_initialize_next;
         r_unlocked    <= w_unlocked_next;
         r_alarm       <= w_alarm_next;
         r_fail_count  <= w_fail_count_next;
      end
   end

   // Next-state selection from current state, accepted keys and timer.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         ST_INIT:    w_state_next = ST_IDLE;
         ST_IDLE: begin
            if (w_digit)                 w_state_next = ST_ENTRY;
            else if (w_star && w_enough) w_state_next = ST_CHECK;
         end
         ST_ENTRY: begin
            if (w_star)                  w_state_next = w_enough ? ST_CHECK : ST_IDLE;
            else if (w_hash)             w_state_next = ST_IDLE;
         end
         ST_CHECK: begin
            if (w_check_now) begin
               if (correct)              w_state_next = ST_OPEN;
               else if (w_trip)          w_state_next = ST_LOCKOUT;
               else                      w_state_next = ST_IDLE;
            end
         end
         ST_OPEN: begin
            if (w_hash)                  w_state_next = ST_SET;
            else if (w_tmr_done)         w_state_next = ST_IDLE;
         end
         ST_SET: begin
            // A pending commit (wr out) always finishes back in IDLE.
            if (r_wr)                    w_state_next = ST_IDLE;
            else if (w_star)             w_state_next = w_enough ? ST_SET : ST_IDLE;
            else if (w_hash)             w_state_next = ST_IDLE;
         end
         ST_LOCKOUT: begin
            if (w_tmr_done)              w_state_next = ST_IDLE;
         end
         default:                        w_state_next = ST_INIT;
      endcase
   end

   // Next registered output values; pulses default low, levels follow state.
   always_comb begin
      w_data_next        = r_data;
      w_cs_next          = 6'd0;
      w_digit_count_next = r_digit_count;
      w_compare_next     = 1'b0;
      w_wr_next          = 1'b0;
      w_clear_input_next = 1'b0;
      w_initialize_next  = 1'b0;
      w_fail_count_next  = r_fail_count;
      w_unlocked_next    = (w_state_next == ST_OPEN);
      w_alarm_next       = (w_state_next == ST_LOCKOUT);

      unique case (r_state)
         ST_INIT: begin
            w_initialize_next  = 1'b1;
            w_clear_input_next = 1'b1;
            w_digit_count_next = 3'd0;
         end
         ST_IDLE, ST_ENTRY: begin
            if (w_digit && w_room) begin
               w_data_next        = key_code;
               w_cs_next          = digit_select(r_digit_count);
               w_digit_count_next = r_digit_count + 3'd1;
            end else if (w_star && w_enough) begin
               w_compare_next     = 1'b1;
            end else if (w_star || (w_hash && (r_state == ST_ENTRY))) begin
               w_clear_input_next = 1'b1;
               w_digit_count_next = 3'd0;
            end
         end
         ST_CHECK: begin
            if (w_check_now) begin
               w_clear_input_next = 1'b1;
               w_digit_count_next = 3'd0;
               w_fail_count_next  = correct ? 2'd0 : w_fail_inc;
            end
         end
         ST_SET: begin
            if (r_wr) begin
               w_clear_input_next = 1'b1;
               w_digit_count_next = 3'd0;
            end else if (w_digit && w_room) begin
               w_data_next        = key_code;
               w_cs_next          = digit_select(r_digit_count);
               w_digit_count_next = r_digit_count + 3'd1;
            end else if (w_star && w_enough) begin
               // Count is held through the commit so storage sees the length.
               w_wr_next          = 1'b1;
            end else if (w_star || w_hash) begin
               w_clear_input_next = 1'b1;
               w_digit_count_next = 3'd0;
            end
         end
         ST_LOCKOUT: begin
            if (w_tmr_done) w_fail_count_next = 2'd0;
         end
         default: begin
         end
      endcase
   end

   assign data        = r_data;
   assign cs          = r_cs;
   assign digit_count = r_digit_count;
   assign compare     = r_compare;
   assign wr          = r_wr;
   assign clear_input = r_clear_input;
   assign initialize  = r_initialize;
   assign unlocked    = r_unlocked;
   assign alarm       = r_alarm;
   assign fail_count  = r_fail_count;

endmodule
`default_nettype wire

// File: tb/tb_lock_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lock_sequencer
//  Description : Self-checking bench for lock_sequencer. Keys are pressed one
//                at a time; a transaction-level model of the lock predicts the
//                pulses, counts and levels each key should produce.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_lock_sequencer;

   localparam int OPEN_N = 20;
   localparam int LOCK_N = 24;
   localparam int GAP    = 5;
   localparam logic [3:0] K_STAR = 4'hA;
   localparam logic [3:0] K_HASH = 4'hB;
   localparam int M_ENTRY = 0, M_OPEN = 1, M_SET = 2, M_LOCK = 3;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic [3:0] key_code = 4'd0;
   logic       correct = 1'b0;
   logic [3:0] data;
   logic [5:0] cs;
   logic [2:0] digit_count;
   logic       compare, wr, clear_input, initialize, unlocked, alarm;
   logic [1:0] fail_count;

   lock_sequencer #(
      .OPEN_CYCLES    (16'(OPEN_N)),
      .LOCKOUT_CYCLES (16'(LOCK_N)),
      .MAX_FAILS      (2'd3)
   ) dut (
      .clk         (clk),
      .reset       (rst_n),
      .key_valid   (key_valid),
      .key_code    (key_code),
      .correct     (correct),
      .data        (data),
      .cs          (cs),
      .digit_count (digit_count),
      .compare     (compare),
      .wr          (wr),
      .clear_input (clear_input),
      .initialize  (initialize),
      .unlocked    (unlocked),
      .alarm       (alarm),
      .fail_count  (fail_count)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Pulse bookkeeping, sampled on the falling edge.
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cs = 0, n_cmp = 0, n_clr = 0, n_wr = 0, n_init = 0;
   int cs_cyc = 0, cmp_cyc = 0, clr_cyc = 0, wr_cyc = 0, wr_cnt_seen = 0;
   logic [5:0] last_cs = '0;
   logic [3:0] last_data = '0;
   int open_start = 0, open_len = -1, alarm_start = 0, alarm_len = -1;
   logic prev_unl = 1'b0, prev_alarm = 1'b0;

   always @(negedge clk) begin
      if (cs != 6'd0) begin
         n_cs++; cs_cyc = cyc; last_cs = cs; last_data = data;
         check("cs_onehot", 32'($countones(cs)), 32'd1);
      end
      if (compare)     begin n_cmp++; cmp_cyc = cyc; end
      if (clear_input) begin n_clr++; clr_cyc = cyc; end
      if (wr) begin
         n_wr++; wr_cyc = cyc; wr_cnt_seen = int'(digit_count);
         check("wr_clear_exclusive", 32'(clear_input), 32'd0);
      end
      if (initialize) n_init++;
      if (unlocked && !prev_unl) open_start = cyc;
      if (!unlocked && prev_unl) open_len = cyc - open_start;
      if (alarm && !prev_alarm) alarm_start = cyc;
      if (!alarm && prev_alarm) alarm_len = cyc - alarm_start;
      prev_unl   = unlocked;
      prev_alarm = alarm;
   end

   // Reference model of the lock as seen from the keypad.
   int m_mode = M_ENTRY, m_count = 0, m_fails = 0;

   task automatic press(input logic [3:0] k);
      int s_cs, s_cmp, s_clr, s_wr, kc;
      int e_cs, e_cmp, e_clr, e_wr, e_clr_off, e_wr_cnt;
      logic [5:0] e_csv;
      e_cs = 0; e_cmp = 0; e_clr = 0; e_wr = 0; e_clr_off = 0; e_wr_cnt = 0; e_csv = '0;
      if (k <= 4'd9 && (m_mode == M_ENTRY || m_mode == M_SET)) begin
         if (m_count < 6) begin
            e_cs = 1; e_csv = 6'b000001 << m_count; m_count++;
         end
      end else if (k == K_STAR && m_mode == M_ENTRY) begin
         e_clr = 1;
         if (m_count >= 4) begin
            e_cmp = 1; e_clr_off = 2;
            if (correct) begin
               m_fails = 0; m_mode = M_OPEN;
            end else begin
               m_fails++;
               if (m_fails >= 3) m_mode = M_LOCK;
            end
         end
         m_count = 0;
      end else if (k == K_HASH && m_mode == M_ENTRY && m_count > 0) begin
         e_clr = 1; m_count = 0;
      end else if (k == K_HASH && m_mode == M_OPEN) begin
         m_mode = M_SET;
      end else if (m_mode == M_SET && (k == K_STAR || k == K_HASH)) begin
         e_clr = 1;
         if (k == K_STAR && m_count >= 4) begin
            e_wr = 1; e_wr_cnt = m_count; e_clr_off = 1;
         end
         m_count = 0; m_mode = M_ENTRY;
      end

      s_cs = n_cs; s_cmp = n_cmp; s_clr = n_clr; s_wr = n_wr;
      @(negedge clk);
      key_valid = 1'b1; key_code = k;
      @(negedge clk);
      key_valid = 1'b0;
      kc = cyc;
      repeat (GAP) @(negedge clk);

      check("cs_pulses", n_cs - s_cs, e_cs);
      if (e_cs != 0) begin
         check("cs_value", 32'(last_cs), 32'(e_csv));
         check("data", 32'(last_data), 32'(k));
         check("cs_latency", cs_cyc, kc);
      end
      check("compare_pulses", n_cmp - s_cmp, e_cmp);
      if (e_cmp != 0) check("compare_latency", cmp_cyc, kc);
      check("clear_pulses", n_clr - s_clr, e_clr);
      if (e_clr != 0) check("clear_latency", clr_cyc, kc + e_clr_off);
      check("wr_pulses", n_wr - s_wr, e_wr);
      if (e_wr != 0) begin
         check("wr_latency", wr_cyc, kc);
         check("wr_digit_count", wr_cnt_seen, e_wr_cnt);
      end
      check("digit_count", 32'(digit_count), m_count);
      check("fail_count", 32'(fail_count), m_fails);
      check("unlocked", 32'(unlocked), 32'(m_mode == M_OPEN));
      check("alarm", 32'(alarm), 32'(m_mode == M_LOCK));
   endtask

   task automatic wait_out_open();
      int t;
      t = 0;
      while (unlocked === 1'b1 && t < 200) begin
         @(negedge clk); t++;
      end
      check("open_timeout", 32'(t < 200), 32'd1);
      repeat (2) @(negedge clk);
      check("open_length", open_len, OPEN_N);
      open_len = -1;
      m_mode = M_ENTRY;
      check("unlocked_after_open", 32'(unlocked), 32'd0);
   endtask

   task automatic wait_out_lock();
      int t;
      t = 0;
      while (alarm === 1'b1 && t < 200) begin
         @(negedge clk); t++;
      end
      check("lockout_timeout", 32'(t < 200), 32'd1);
      repeat (2) @(negedge clk);
      check("lockout_length", alarm_len, LOCK_N);
      alarm_len = -1;
      m_mode = M_ENTRY; m_fails = 0;
      check("fail_after_lockout", 32'(fail_count), 32'd0);
   endtask

   task automatic check_reset_release();
      int s_init, s_clr;
      s_init = n_init; s_clr = n_clr;
      rst_n = 1'b1;
      repeat (4) @(negedge clk);
      check("init_pulses", n_init - s_init, 1);
      check("init_clear_pulses", n_clr - s_clr, 1);
      m_mode = M_ENTRY; m_count = 0; m_fails = 0;
   endtask

   task automatic entry(input int nd, input logic ok);
      for (int d = 0; d < nd; d++) press(4'($urandom_range(0, 9)));
      correct = ok;
      press(K_STAR);
   endtask

   task automatic handle_open();
      int choice, sel, nd;
      choice = int'($urandom_range(0, 2));
      if (choice == 2) begin
         press(K_HASH);
         nd = int'($urandom_range(0, 7));
         for (int d = 0; d < nd; d++) press(4'($urandom_range(0, 9)));
         press(($urandom_range(0, 3) == 0) ? K_HASH : K_STAR);
      end else begin
         if (choice == 1) begin
            sel = int'($urandom_range(0, 2));
            if (sel == 0)      press(4'($urandom_range(0, 9)));
            else if (sel == 1) press(K_STAR);
            else               press(4'hC + 4'($urandom_range(0, 3)));
         end
         wait_out_open();
      end
   endtask

   initial begin
      #5000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nd, pick;
      logic [3:0] k;

      // Reset state and INIT pulses.
      repeat (3) @(negedge clk);
      check("reset_outputs", 32'({data, cs, digit_count, compare, wr, clear_input,
                                  initialize, unlocked, alarm, fail_count}), 32'd0);
      check_reset_release();

      // Correct 4-digit entry, door held open for the full window.
      press(4'd1); press(4'd2); press(4'd3); press(4'd4);
      correct = 1'b1; press(K_STAR);
      wait_out_open();

      // Too-short entry is cleared without a compare.
      press(4'd1); press(4'd2); press(4'd3);
      correct = 1'b0; press(K_STAR);

      // Three wrong entries trip the lockout; keys are ignored meanwhile.
      entry(4, 1'b0); entry(5, 1'b0); entry(6, 1'b0);
      press(4'd7);
      wait_out_lock();

      // Seventh digit ignored, compare still issued at six.
      for (int d = 0; d < 7; d++) press(4'(d + 1));
      correct = 1'b0; press(K_STAR);

      // Password change from OPEN with five digits.
      entry(4, 1'b1);
      press(K_HASH);
      press(4'd9); press(4'd8); press(4'd7); press(4'd6); press(4'd5);
      press(K_STAR);

      // Randomized sessions.
      for (int it = 0; it < 40; it++) begin
         nd = int'($urandom_range(0, 7));
         for (int d = 0; d < nd; d++) begin
            pick = int'($urandom_range(0, 19));
            if (pick == 0)      k = K_HASH;
            else if (pick == 1) k = 4'hC + 4'($urandom_range(0, 3));
            else                k = 4'($urandom_range(0, 9));
            press(k);
         end
         correct = ($urandom_range(0, 1) == 1);
         press(K_STAR);
         if (m_mode == M_OPEN) begin
            handle_open();
         end else if (m_mode == M_LOCK) begin
            press(4'($urandom_range(0, 11)));
            wait_out_lock();
         end
      end

      // Asynchronous reset in the middle of an entry.
      press(4'd4); press(4'd5); press(4'd6);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1 check("midreset_outputs", 32'({data, cs, digit_count, compare, wr, clear_input,
                                        initialize, unlocked, alarm, fail_count}), 32'd0);
      repeat (2) @(negedge clk);
      check_reset_release();
      press(4'd2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
